shift_register: RTL and testbench



---
 rtl/shift_register.sv | 49 ++++
 tb/tb_shift_register.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// shift_register: synchronous shift register with parallel load.
// Used as a global branch-history register. Bit 0 holds the most recent
// outcome. The oldest bit falls off the top on every shift.
module shift_register #(
  parameter int unsigned           bus_width   = 10,
  parameter logic [bus_width-1:0]  RESET_VALUE = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 write_en,
  input  logic                 shift_en,
  input  logic                 shift_i,
  input  logic [bus_width-1:0] data_i,
  output logic [bus_width-1:0] data_o
);

  // Reject unsupported widths when the design is elaborated
  generate
    if ((bus_width < 1) || (bus_width > 64)) begin : g_bad_width
      $error("shift_register: bus_width must be in 1..64");
    end
  endgenerate

  logic [bus_width-1:0] r_hist;
  logic [bus_width-1:0] w_shifted;

  // Width 1 has no lower bits to keep, so the shifted value is just the new bit
  generate
    if (bus_width == 1) begin : g_w1
      assign w_shifted = shift_i;
    end else begin : g_wn
      assign w_shifted = {r_hist[bus_width-2:0], shift_i};
    end
  endgenerate

  // History update: reset, then load, then shift, otherwise hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hist <= RESET_VALUE;
    end else if (write_en) begin
      r_hist <= data_i;
    end else if (shift_en) begin
      r_hist <= w_shifted;
    end
  end

  assign data_o = r_hist;

endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register: directed plus randomized scoreboard bench for
// shift_register at widths 10 and 1.
module tb_shift_register;

  logic       clk;
  logic       rst10, we10, se10, si10;
  logic [9:0] di10, do10;
  logic       rst1, we1, se1, si1;
  logic [0:0] di1, do1;

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0] q10[$];
  logic [0:0] q1[$];
  logic [9:0] m10;

  shift_register #(.bus_width(10)) u_dut10 (
    .clk_i    (clk),
    .rst_i    (rst10),
    .write_en (we10),
    .shift_en (se10),
    .shift_i  (si10),
    .data_i   (di10),
    .data_o   (do10)
  );

  shift_register #(.bus_width(1)) u_dut1 (
    .clk_i    (clk),
    .rst_i    (rst1),
    .write_en (we1),
    .shift_en (se1),
    .shift_i  (si1),
    .data_i   (di1),
    .data_o   (do1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent behavioural reference for the width-10 register
  function automatic logic [9:0] ref10(input logic [9:0] cur, input logic r,
                                       input logic w, input logic s,
                                       input logic b, input logic [9:0] d);
    if (r)      return 10'h000;
    else if (w) return d;
    else if (s) return {cur[8:0], b};
    else        return cur;
  endfunction

  task automatic s10(input string tag, input logic r, input logic w,
                     input logic s, input logic b, input logic [9:0] d,
                     input logic [9:0] exp);
    logic [9:0] e;
    @(negedge clk);
    rst10 = r; we10 = w; se10 = s; si10 = b; di10 = d;
    q10.push_back(exp);
    @(posedge clk);
    #1;
    e = q10.pop_front();
    n_total++;
    assert (do10 === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, do10, e);
  endtask

  task automatic s1(input string tag, input logic r, input logic w,
                    input logic s, input logic b, input logic d,
                    input logic exp);
    logic [0:0] e;
    @(negedge clk);
    rst1 = r; we1 = w; se1 = s; si1 = b; di1 = d;
    q1.push_back(exp);
    @(posedge clk);
    #1;
    e = q1.pop_front();
    n_total++;
    assert (do1 === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, do1, e);
  endtask

  initial begin
    rst10 = 0; we10 = 0; se10 = 0; si10 = 0; di10 = '0;
    rst1  = 0; we1  = 0; se1  = 0; si1  = 0; di1  = '0;

    // Reset and reset priority over load/shift
    s10("reset_init", 1, 0, 0, 0, 10'h000, 10'h000);
    s10("preload",    0, 1, 0, 0, 10'h3FF, 10'h3FF);
    s10("reset_prio", 1, 1, 1, 1, 10'h2AA, 10'h000);

    // Shift sequence 1,0,1,1
    s10("shift_1", 0, 0, 1, 1, 10'h000, 10'h001);
    s10("shift_2", 0, 0, 1, 0, 10'h000, 10'h002);
    s10("shift_3", 0, 0, 1, 1, 10'h000, 10'h005);
    s10("shift_4", 0, 0, 1, 1, 10'h000, 10'h00B);

    // MSB discard
    s10("load_200",  0, 1, 0, 0, 10'h200, 10'h200);
    s10("drop_msb",  0, 0, 1, 0, 10'h000, 10'h000);
    s10("load_3ff",  0, 1, 0, 0, 10'h3FF, 10'h3FF);
    s10("shift_3fe", 0, 0, 1, 0, 10'h000, 10'h3FE);

    // Load wins over shift
    s10("load_00f",  0, 1, 0, 0, 10'h00F, 10'h00F);
    s10("load_prio", 0, 1, 1, 1, 10'h155, 10'h155);

    // Hold with toggling data_i/shift_i
    for (int unsigned i = 0; i < 5; i++)
      s10("hold", 0, 0, 0, i[0], (i[0] ? 10'h2AA : 10'h155), 10'h155);

    // Reset mid-stream discards the shift in progress
    s10("shift_pre", 0, 0, 1, 1, 10'h000, 10'h2AB);
    s10("reset_mid", 1, 0, 1, 1, 10'h000, 10'h000);

    // Continuous shifting fills the register with new bits only
    s10("load_mix", 0, 1, 0, 0, 10'h2A5, 10'h2A5);
    for (int unsigned i = 0; i < 9; i++)
      s10("fill", 0, 0, 1, 1, 10'h000, (10'h2A5 << (i + 1)) | ((10'h1 << (i + 1)) - 10'h1));
    s10("fill_full", 0, 0, 1, 1, 10'h000, 10'h3FF);

    // Randomized traffic against the reference model
    m10 = 10'h3FF;
    for (int unsigned i = 0; i < 60; i++) begin
      logic r, w, s, b;
      logic [9:0] d;
      r = ($urandom_range(0, 15) == 0);
      w = ($urandom_range(0, 5) == 0);
      s = $urandom_range(0, 1);
      b = $urandom_range(0, 1);
      d = 10'($urandom);
      m10 = ref10(m10, r, w, s, b, d);
      s10("random", r, w, s, b, d, m10);
    end

    // Width-1 corner
    s1("w1_reset",  1, 0, 0, 0, 0, 1'b0);
    s1("w1_shift1", 0, 0, 1, 1, 0, 1'b1);
    s1("w1_shift0", 0, 0, 1, 0, 0, 1'b0);
    s1("w1_load",   0, 1, 0, 0, 1, 1'b1);
    s1("w1_hold",   0, 0, 0, 0, 0, 1'b1);
    s1("w1_prio",   0, 1, 1, 0, 1, 1'b1);
    s1("w1_rst",    1, 1, 1, 1, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
